// File: rtl/dpwm_ref_ctrl_if.sv
`timescale 1ns/1ps
// rtl/dpwm_ref_ctrl_if.sv - duty target request handshake into dpwm_ref_ctrl
interface dpwm_ref_ctrl_if #(
    parameter int REF_W = 4
);
    logic             target_valid;
    logic [REF_W-1:0] target;
    logic             target_ready;

    modport master (
        output target_valid,
        output target,
        input  target_ready
    );

    modport slave (
        input  target_valid,
        input  target,
        output target_ready
    );
endinterface

// File: rtl/dpwm_ref_ctrl.sv
`timescale 1ns/1ps
// rtl/dpwm_ref_ctrl.sv - soft-start / duty-reference sequencer for the DPWM Ref input
// Ref moves one LSB per step interval, only on the edge that wraps the PWM period counter.
module dpwm_ref_ctrl #(
    parameter int REF_W        = 4,
    parameter int STEP_PERIODS = 1,
    parameter int MAX_REF      = 15
) (
    input  logic             f_in,
    input  logic             rst,
    input  logic             en,
    dpwm_ref_ctrl_if.slave   tgt_bus,
    output logic [REF_W-1:0] Ref,
    output logic             period_start,
    output logic             ramping,
    output logic             at_target
);

    localparam int                SCNT_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [REF_W-1:0]  PCNT_LAST = {REF_W{1'b1}};
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);
    localparam logic [REF_W-1:0]  MAX_REF_L = REF_W'(MAX_REF);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_PERIODS - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_SHUTDOWN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REF_W-1:0]  r_pcnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [REF_W-1:0]  r_tgt;
    logic [REF_W-1:0]  r_ref;
    logic [REF_W-1:0]  w_tgt_nxt;
    logic [REF_W-1:0]  w_ref_nxt;
    logic [REF_W-1:0]  w_target_clamped;
    logic              w_pwrap;
    logic              w_step;
    logic              w_accept;

    assign w_pwrap          = (r_pcnt == PCNT_LAST);
    assign w_step           = w_pwrap && (r_scnt == SCNT_LAST);
    assign w_accept         = tgt_bus.target_valid && (r_state == ST_RUN);
    assign w_target_clamped = (tgt_bus.target > MAX_REF_L) ? MAX_REF_L : tgt_bus.target;

    // Period and step-interval counters run in every state, OFF included.
    always_ff @(posedge f_in or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_scnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + REF_ONE;
            if (w_pwrap) begin
                r_scnt <= (r_scnt == SCNT_LAST) ? '0 : (r_scnt + SCNT_ONE);
            end
        end
    end

    always_ff @(posedge f_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_tgt   <= '0;
            r_ref   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_ref   <= w_ref_nxt;
        end
    end

    // The step always compares against the registered tgt, so a target accepted
    // on a step edge only takes effect from the following step edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_ref_nxt   = r_ref;

        if (w_step) begin
            if (r_ref < r_tgt) begin
                w_ref_nxt = r_ref + REF_ONE;
            end else if (r_ref > r_tgt) begin
                w_ref_nxt = r_ref - REF_ONE;
            end
        end

        case (r_state)
            ST_OFF: begin
                w_tgt_nxt = '0;
                w_ref_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_SHUTDOWN;
                    w_tgt_nxt   = '0;
                end else if (w_accept) begin
                    w_tgt_nxt = w_target_clamped;
                end
            end
            ST_SHUTDOWN: begin
                w_tgt_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step && (r_ref <= REF_ONE)) begin
                    w_state_nxt = ST_OFF;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_tgt_nxt   = '0;
                w_ref_nxt   = '0;
            end
        endcase
    end

    assign tgt_bus.target_ready = (r_state == ST_RUN);
    assign Ref                  = r_ref;
    assign period_start         = (r_pcnt == '0);
    assign ramping              = (r_state != ST_OFF) && (r_ref != r_tgt);
    assign at_target            = (r_state == ST_RUN) && (r_ref == r_tgt);

endmodule

// File: tb/tb_dpwm_ref_ctrl.sv
`timescale 1ns/1ps
// tb/tb_dpwm_ref_ctrl.sv - self-checking bench for dpwm_ref_ctrl
module tb_dpwm_ref_ctrl;

    localparam int REF_W  = 4;
    localparam int PERIOD = 16;

    typedef struct {
        logic [REF_W-1:0] target;
        logic [REF_W-1:0] exp_ref;
        int               exp_steps;
    } vec_t;

    logic             f_in = 1'b0;
    logic             rst;
    logic             en_a;
    logic             en_b;
    logic [REF_W-1:0] ref_a;
    logic [REF_W-1:0] ref_b;
    logic             ps_a, ps_b, ramp_a, ramp_b, at_a, at_b;

    dpwm_ref_ctrl_if #(.REF_W(REF_W)) bus_a ();
    dpwm_ref_ctrl_if #(.REF_W(REF_W)) bus_b ();

    dpwm_ref_ctrl #(.REF_W(REF_W), .STEP_PERIODS(1), .MAX_REF(15)) u_a (
        .f_in(f_in), .rst(rst), .en(en_a), .tgt_bus(bus_a.slave),
        .Ref(ref_a), .period_start(ps_a), .ramping(ramp_a), .at_target(at_a)
    );

    dpwm_ref_ctrl #(.REF_W(REF_W), .STEP_PERIODS(2), .MAX_REF(12)) u_b (
        .f_in(f_in), .rst(rst), .en(en_b), .tgt_bus(bus_b.slave),
        .Ref(ref_b), .period_start(ps_b), .ramping(ramp_b), .at_target(at_b)
    );

    always #1000 f_in = ~f_in;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               chg_a   = 0;
    logic [REF_W-1:0] q_a[$];
    logic [REF_W-1:0] q_b[$];
    logic [REF_W-1:0] prev_ref_a = '0;
    logic [REF_W-1:0] exp_tgt_a  = '0;
    logic             run_a      = 1'b0;
    vec_t             vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ramp_a(input int from, input int to);
        int v = from;
        while (v != to) begin
            v = (to > v) ? v + 1 : v - 1;
            q_a.push_back(REF_W'(v));
        end
    endtask

    task automatic wait_ref_a(input int want, input int budget, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge f_in);
            if (ref_a == REF_W'(want) && q_a.size() == 0) hit = 1'b1;
        end
        check({name, "_reached"}, int'(hit), 1);
    endtask

    // Scoreboard for DUT A: every Ref change must be the next queued value,
    // land on a period start, and carry consistent status flags.
    always @(negedge f_in) begin
        if (rst) begin
            prev_ref_a = '0;
        end else if (ref_a != prev_ref_a) begin
            chg_a++;
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ref_a_unexpected: got %0d, expected no change from %0d (t=%0t)",
                         ref_a, prev_ref_a, $time);
            end else begin
                check("ref_a_step", ref_a, q_a.pop_front());
            end
            check("ref_a_on_period_start", ps_a, 1);
            check("at_target_a_on_step", at_a, int'(run_a && (ref_a == exp_tgt_a)));
            check("ramping_a_on_step", ramp_a, int'(ref_a != exp_tgt_a));
            prev_ref_a = ref_a;
        end
    end

    initial begin
        #(40_000_000);
        $display("FAIL watchdog: got timeout, expected $finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        int c0;
        int cnt;
        int last_k;
        int chg_b;
        logic [REF_W-1:0] prev_b;
        bit seen;

        vecs[0] = '{target: 4'd9,  exp_ref: 4'd9,  exp_steps: 9};
        vecs[1] = '{target: 4'd1,  exp_ref: 4'd1,  exp_steps: 8};
        vecs[2] = '{target: 4'd4,  exp_ref: 4'd4,  exp_steps: 3};
        vecs[3] = '{target: 4'd4,  exp_ref: 4'd4,  exp_steps: 0};
        vecs[4] = '{target: 4'd15, exp_ref: 4'd15, exp_steps: 11};
        vecs[5] = '{target: 4'd5,  exp_ref: 4'd5,  exp_steps: 10};

        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        bus_a.target_valid = 1'b0;
        bus_a.target = '0;
        bus_b.target_valid = 1'b0;
        bus_b.target = '0;

        // Reset values, before any clock edge
        #301;
        check("rst_ref_a", ref_a, 0);
        check("rst_ps_a", ps_a, 1);
        check("rst_ramp_a", ramp_a, 0);
        check("rst_at_a", at_a, 0);
        check("rst_ready_a", bus_a.target_ready, 0);
        check("rst_ref_b", ref_b, 0);
        check("rst_ready_b", bus_b.target_ready, 0);

        repeat (2) @(negedge f_in);
        rst = 1'b0;

        // Period counter free-runs while OFF
        cnt = 0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(negedge f_in);
            if (ps_a) cnt++;
            check("off_ready_a", bus_a.target_ready, 0);
        end
        check("off_period_starts", cnt, 2);

        // Clamp and step rate on DUT B (MAX_REF=12, STEP_PERIODS=2)
        en_b = 1'b1;
        @(negedge f_in);
        check("b_ready", bus_b.target_ready, 1);
        bus_b.target_valid = 1'b1;
        bus_b.target = 4'd15;
        for (int v = 1; v <= 12; v++) q_b.push_back(REF_W'(v));
        @(negedge f_in);
        bus_b.target_valid = 1'b0;
        check("b_ramp_start", ramp_b, 1);
        prev_b = '0;
        last_k = -1;
        chg_b = 0;
        for (int k = 0; k < 13 * 2 * PERIOD + 100; k++) begin
            @(negedge f_in);
            if (ref_b != prev_b) begin
                chg_b++;
                if (q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected: got %0d, expected hold at %0d", ref_b, prev_b);
                end else begin
                    check("b_step", ref_b, q_b.pop_front());
                end
                check("b_on_period_start", ps_b, 1);
                if (last_k >= 0) check("b_step_interval", k - last_k, 2 * PERIOD);
                last_k = k;
                prev_b = ref_b;
            end
        end
        check("b_final_ref", ref_b, 12);
        check("b_final_at", at_b, 1);
        check("b_final_ramp", ramp_b, 0);
        check("b_steps", chg_b, 12);
        check("b_queue_empty", q_b.size(), 0);
        en_b = 1'b0;

        // Table-driven retargets on DUT A: soft-start, retarget down, no-op, full scale
        en_a = 1'b1;
        run_a = 1'b1;
        exp_tgt_a = '0;
        @(negedge f_in);
        cur = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge f_in);
            check($sformatf("v%0d_ready", i), bus_a.target_ready, 1);
            c0 = chg_a;
            bus_a.target_valid = 1'b1;
            bus_a.target = vecs[i].target;
            push_ramp_a(cur, int'(vecs[i].exp_ref));
            exp_tgt_a = vecs[i].exp_ref;
            @(negedge f_in);
            bus_a.target_valid = 1'b0;
            check($sformatf("v%0d_ramp_start", i), ramp_a, int'(cur != int'(vecs[i].exp_ref)));
            wait_ref_a(int'(vecs[i].exp_ref), (vecs[i].exp_steps + 2) * PERIOD + 8,
                       $sformatf("v%0d", i));
            repeat (2 * PERIOD) @(negedge f_in);
            check($sformatf("v%0d_ref", i), ref_a, vecs[i].exp_ref);
            check($sformatf("v%0d_at", i), at_a, 1);
            check($sformatf("v%0d_ramp", i), ramp_a, 0);
            check($sformatf("v%0d_steps", i), chg_a - c0, vecs[i].exp_steps);
            cur = int'(vecs[i].exp_ref);
        end

        // Shutdown from Ref=5, with an ignored request mid-ramp
        @(negedge f_in);
        c0 = chg_a;
        en_a = 1'b0;
        run_a = 1'b0;
        exp_tgt_a = '0;
        push_ramp_a(5, 0);
        @(negedge f_in);
        check("sd_ready_low", bus_a.target_ready, 0);
        repeat (20) @(negedge f_in);
        bus_a.target_valid = 1'b1;
        bus_a.target = 4'd12;
        @(negedge f_in);
        check("sd_ready_low_mid", bus_a.target_ready, 0);
        bus_a.target_valid = 1'b0;
        wait_ref_a(0, 7 * PERIOD, "sd");
        repeat (2 * PERIOD) @(negedge f_in);
        check("sd_ref", ref_a, 0);
        check("sd_ready", bus_a.target_ready, 0);
        check("sd_ramp", ramp_a, 0);
        check("sd_at", at_a, 0);
        check("sd_steps", chg_a - c0, 5);

        // Async reset mid-ramp at Ref=6
        en_a = 1'b1;
        run_a = 1'b1;
        exp_tgt_a = '0;
        @(negedge f_in);
        bus_a.target_valid = 1'b1;
        bus_a.target = 4'd9;
        push_ramp_a(0, 6);
        exp_tgt_a = 4'd9;
        @(negedge f_in);
        bus_a.target_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 * PERIOD && !seen; k++) begin
            @(negedge f_in);
            if (ref_a == 4'd6) seen = 1'b1;
        end
        check("ar_reached_6", int'(seen), 1);
        repeat (2) @(negedge f_in);
        #300;
        rst = 1'b1;
        #1;
        check("ar_ref", ref_a, 0);
        check("ar_ramp", ramp_a, 0);
        check("ar_at", at_a, 0);
        check("ar_ps", ps_a, 1);
        check("ar_ready", bus_a.target_ready, 0);
        q_a.delete();
        en_a = 1'b0;
        run_a = 1'b0;
        exp_tgt_a = '0;
        repeat (2) @(negedge f_in);
        rst = 1'b0;
        bus_a.target_valid = 1'b1;
        bus_a.target = 4'd7;
        repeat (3 * PERIOD) @(negedge f_in);
        check("ar_stays_off_ref", ref_a, 0);
        check("ar_stays_off_ready", bus_a.target_ready, 0);
        bus_a.target_valid = 1'b0;

        // Accept coinciding with a step edge: Ref=5, tgt=9, new target 3
        en_a = 1'b1;
        run_a = 1'b1;
        @(negedge f_in);
        check("co_ready", bus_a.target_ready, 1);
        bus_a.target_valid = 1'b1;
        bus_a.target = 4'd9;
        push_ramp_a(0, 5);
        exp_tgt_a = 4'd9;
        @(negedge f_in);
        bus_a.target_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 7 * PERIOD && !seen; k++) begin
            @(negedge f_in);
            if (ref_a == 4'd5) seen = 1'b1;
        end
        check("co_reached_5", int'(seen), 1);
        repeat (PERIOD - 1) @(negedge f_in);
        c0 = chg_a;
        bus_a.target_valid = 1'b1;
        bus_a.target = 4'd3;
        exp_tgt_a = 4'd3;
        q_a.push_back(4'd6);
        push_ramp_a(6, 3);
        @(negedge f_in);
        bus_a.target_valid = 1'b0;
        check("co_ref_6", ref_a, 6);
        wait_ref_a(3, 5 * PERIOD + 8, "co");
        check("co_at", at_a, 1);
        check("co_steps", chg_a - c0, 4);

        check("final_queue_a_empty", q_a.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
